// File: rtl/pipe_pkg.sv
// Shared types for the forwarding tap pipe.
// Entry record carried through each delay stage.
package pipe_pkg;

  localparam int RD_W     = 5;
  localparam int XLEN     = 32;
  localparam int STEP_DEF = 4;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic            data_ok;
  } fwd_entry_t;

  typedef fwd_entry_t [STEP_DEF-1:0] fwd_stages_t;

endpackage

// File: rtl/fwd_match.sv
// Youngest-wins priority matcher over the in-flight stages.
// Index STEP-1 is youngest; x0 never matches.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int STEP = STEP_DEF
) (
  input  fwd_entry_t [STEP-1:0] ent,
  input  logic [RD_W-1:0]       rs,
  output logic                  hit,
  output logic [XLEN-1:0]       data,
  output logic                  pend
);

  // Scan oldest to youngest so later (younger) matches override.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    pend = 1'b0;
    if (rs != '0) begin
      for (int i = 0; i < STEP; i++) begin
        if (ent[i].valid && ent[i].we && ent[i].rd == rs) begin
          hit  = 1'b1;
          data = ent[i].data;
          pend = ~ent[i].data_ok;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_tap_pipe.sv
// Destination-tracking delay line with two forwarding query ports.
// Stage STEP-1 is youngest, stage 0 drives writeback.
module fwd_tap_pipe
  import pipe_pkg::*;
#(
  parameter int STEP       = STEP_DEF,
  parameter int FLUSH_FROM = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            in_we,
  input  logic [RD_W-1:0] in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_data_ok,
  output logic            out_valid,
  output logic            out_we,
  output logic [RD_W-1:0] out_rd,
  output logic [XLEN-1:0] out_data,
  input  logic [RD_W-1:0] rs1,
  input  logic [RD_W-1:0] rs2,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data,
  output logic            ld_use_stall
);

  fwd_entry_t [STEP-1:0] st_q;
  fwd_entry_t [STEP-1:0] st_d;
  fwd_entry_t            in_ent;
  logic                  pend1;
  logic                  pend2;

  // Next stage contents: shift on advance or flush, then kill young slots.
  always_comb begin
    in_ent.valid   = in_valid;
    in_ent.we      = in_we & in_valid & (in_rd != '0);
    in_ent.rd      = in_rd;
    in_ent.data    = in_data;
    in_ent.data_ok = in_data_ok;
    st_d = st_q;
    if (flush || !stall) begin
      for (int i = 0; i < STEP - 1; i++) begin
        st_d[i] = st_q[i+1];
      end
      st_d[STEP-1] = in_ent;
    end
    if (flush) begin
      for (int i = 0; i < STEP; i++) begin
        if (i >= FLUSH_FROM) begin
          st_d[i].valid = 1'b0;
          st_d[i].we    = 1'b0;
        end
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end

  // Writeback view of the oldest stage.
  always_comb begin
    out_valid = st_q[0].valid;
    out_we    = st_q[0].we;
    out_rd    = st_q[0].rd;
    out_data  = st_q[0].data;
  end

  fwd_match #(.STEP(STEP)) u_m1 (
    .ent  (st_q),
    .rs   (rs1),
    .hit  (fwd1_hit),
    .data (fwd1_data),
    .pend (pend1)
  );

  fwd_match #(.STEP(STEP)) u_m2 (
    .ent  (st_q),
    .rs   (rs2),
    .hit  (fwd2_hit),
    .data (fwd2_data),
    .pend (pend2)
  );

  // Any winner still waiting on load data holds decode.
  always_comb begin
    ld_use_stall = pend1 | pend2;
  end

endmodule

// File: doc/fwd_tap_pipe.md
Name: fwd_tap_pipe

Overview:
- Destination-tracking delay line for the pipeline, STEP stages deep. Each cycle it accepts one retiring-instruction record (valid, we, rd, data, data_ok) at the young end and presents the oldest record at the old end for writeback.
- Its main job is the read side. Two source-register query ports search all in-flight stages and return forwarding data, or a load-use stall request.
- It sits beside the EX/MEM/WB stage registers and feeds the ID-stage operand muxes and the hazard unit.

Parameters:
- STEP, 4, number of stages; stage STEP-1 is youngest, stage 0 is oldest/output; minimum 2.
- RD_W, 5, register index width.
- XLEN, 32, data width.
- FLUSH_FROM, 2, flush invalidates stages FLUSH_FROM..STEP-1 and the incoming record; 0 <= FLUSH_FROM <= STEP-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  freeze all stages; no capture of in_*.
- flush  in  1  invalidate young stages (see FLUSH_FROM).
- in_valid  in  1  record present.
- in_we  in  1  record writes rd.
- in_rd  in  RD_W  destination index.
- in_data  in  XLEN  result value.
- in_data_ok  in  1  in_data is final; 0 for a load still in flight.
- out_valid  out  1  stage-0 valid.
- out_we  out  1  stage-0 we.
- out_rd  out  RD_W  stage-0 rd.
- out_data  out  XLEN  stage-0 data.
- rs1, rs2  in  RD_W each  query indices.
- fwd1_hit, fwd2_hit  out  1 each  a matching in-flight writer exists.
- fwd1_data, fwd2_data  out  XLEN each  data of the youngest matching writer.
- ld_use_stall  out  1  any hit whose matched entry has data_ok=0.

Behaviour:
- Reset (rst_n=0, async): all stage fields clear to 0. All out_*, fwd*_hit, fwd*_data and ld_use_stall read 0 while rst_n is low and after release. Asserting reset mid-operation discards every record immediately.
- Capture: in_we is stored as in_we & in_valid & (in_rd != 0). An x0 write is never trackable.
- Normal edge (stall=0, flush=0):
  - stage[i] <= stage[i+1] for i < STEP-1.
  - stage[STEP-1] <= incoming record.
  - A record reaches out_* exactly STEP edges after capture.
- stall=1, flush=0: all stages hold; in_* is dropped (the upstream holds its own record).
- flush=1, priority over stall:
  - Shift as in the normal case.
  - Then clear the valid/we bits of every post-shift stage with index >= FLUSH_FROM, including the new STEP-1 entry.
  - Data bits may keep stale values but are never observable through hit logic.
- Query, combinational on registered state only:
  - For each port: if rs == 0, hit = 0.
  - Otherwise, scan from stage STEP-1 down to stage 0. The first stage with valid & we & rd==rs wins.
  - hit = 1 and data = that stage's data.
  - Per-port stall term = hit & ~data_ok of the winner; ld_use_stall = term1 | term2.
  - The in_* record on the current cycle is never visible to queries (no input bypass).
  - No hit: data = 0.
- Priority: the youngest match shadows older matches, even if the younger entry has data_ok=0. In that case ld_use_stall=1 and fwd data is the younger, not-yet-valid value.
- Outputs are combinational from stage registers, with zero added latency.

Decomposition:
- Package pipe_pkg:
  - Constants RD_W, XLEN.
  - typedef struct packed fwd_entry_t {valid, we, rd, data, data_ok}.
  - typedef fwd_entry_t array type for the stages.
- Sub-module fwd_match: pure priority matcher, one instance per query port.
  - Inputs: the entry array and rs.
  - Outputs: hit, data, pend.

Test Plan:
- Reset, then release with no pushes → all outputs 0. Push {we=1, rd=5, data=0xA5, ok=1} for 1 cycle → out_valid=1, out_rd=5, out_data=0xA5 exactly 4 edges later, and 0 on the next edge.
- Push rd=3 data=0x11 on cycle 0, then rd=3 data=0x22 on cycle 1, query rs1=3 after cycle 1 → fwd1_hit=1, fwd1_data=0x22 (youngest wins). After the 0x22 record leaves stage 0, hit=0.
- Push rd=0 data=0xFF, query rs1=rs2=0 → fwd*_hit=0. The record appears at out with out_we=0.
- Push load {rd=7, ok=0}, query rs2=7 → ld_use_stall=1, fwd2_hit=1. Hold stall=1 for 3 cycles → stage contents and outputs unchanged, in_* ignored.
- Fill stages with rd=1..4, pulse flush with FLUSH_FROM=2 → after the edge only the records formerly in stages 1..2 remain (now in stages 0..1). Queries for the flushed rds miss. stall=1 with flush=1 still shifts.
- Assert rst_n=0 asynchronously mid-stream, between clock edges → outputs and hits drop to 0 before the next edge. Data flow restarts cleanly after release.
